// File: rtl/ps2_pkg.sv
// Shared types and scan-code tables for the PS/2 keyboard front end.
package ps2_pkg;

    typedef enum logic [1:0] {IDLE, RECV, STOP, DECODE} ps2_state_e;

    typedef logic [2:0] game_cmd_t;

    localparam game_cmd_t CMD_NONE   = 3'd0;
    localparam game_cmd_t CMD_UP     = 3'd1;
    localparam game_cmd_t CMD_DOWN   = 3'd2;
    localparam game_cmd_t CMD_LEFT   = 3'd3;
    localparam game_cmd_t CMD_RIGHT  = 3'd4;
    localparam game_cmd_t CMD_SELECT = 3'd5;
    localparam game_cmd_t CMD_HALF   = 3'd6;
    localparam game_cmd_t CMD_TURN   = 3'd7;

    localparam logic [7:0] SC_EXT = 8'hE0;
    localparam logic [7:0] SC_BRK = 8'hF0;

    typedef struct packed {
        logic      valid;
        game_cmd_t cmd;
    } cmd_map_t;

    function automatic cmd_map_t map_scancode(input logic ext, input logic [7:0] code);
        cmd_map_t m;
        m.valid = 1'b1;
        m.cmd   = CMD_NONE;
        case ({ext, code})
            {1'b0, 8'h1C}: m.cmd = CMD_LEFT;
            {1'b0, 8'h23}: m.cmd = CMD_RIGHT;
            {1'b0, 8'h1D}: m.cmd = CMD_UP;
            {1'b0, 8'h1B}: m.cmd = CMD_DOWN;
            {1'b0, 8'h3B}: m.cmd = CMD_SELECT;
            {1'b0, 8'h42}: m.cmd = CMD_HALF;
            {1'b0, 8'h29}: m.cmd = CMD_TURN;
            {1'b1, 8'h75}: m.cmd = CMD_UP;
            {1'b1, 8'h72}: m.cmd = CMD_DOWN;
            {1'b1, 8'h6B}: m.cmd = CMD_LEFT;
            {1'b1, 8'h74}: m.cmd = CMD_RIGHT;
            default:       m.valid = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Brings the raw PS/2 clock/data lines into the system clock domain and
// produces a one-cycle strobe on each synced falling edge of the PS/2 clock.
module ps2_line_sync (
    input  logic clock,
    input  logic reset,
    input  logic ps2_clock,
    input  logic ps2_data,
    output logic fall,
    output logic data_sync
);

    logic [2:0] clk_pipe_q, clk_pipe_d;
    logic [1:0] data_pipe_q, data_pipe_d;
    logic       fall_q, fall_d;

    always_comb begin
        clk_pipe_d  = {clk_pipe_q[1:0], ps2_clock};
        data_pipe_d = {data_pipe_q[0], ps2_data};
        // Third clock stage holds the previous synced level for edge detection.
        fall_d      = clk_pipe_q[2] & ~clk_pipe_q[1];
    end

    // NOTE: sequential state is only ever written with <= in always_ff; all next-state logic lives in always_comb.
    always_ff @(posedge clock) begin
        if (reset) begin
            clk_pipe_q  <= 3'b111;
            data_pipe_q <= 2'b11;
            fall_q      <= 1'b0;
        end else begin
            clk_pipe_q  <= clk_pipe_d;
            data_pipe_q <= data_pipe_d;
            fall_q      <= fall_d;
        end
    end

    assign fall      = fall_q;
    assign data_sync = data_pipe_q[1];

endmodule

// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard receiver: deserialises device-to-host frames, tracks E0/F0
// prefixes and turns game-key make codes into one-cycle command strobes.
module ps2_key_receiver
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 200000,
    parameter bit REPEAT_EN      = 1'b0,
    parameter int ERR_W          = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ps2_clock,
    input  logic             ps2_data,
    output logic             cmd_valid,
    output logic [2:0]       cmd_data,
    output logic             frame_err,
    output logic [ERR_W-1:0] err_count
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic fall;
    logic data;

    ps2_line_sync u_sync (
        .clock     (clock),
        .reset     (reset),
        .ps2_clock (ps2_clock),
        .ps2_data  (ps2_data),
        .fall      (fall),
        .data_sync (data)
    );

    ps2_state_e       state_q, state_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             parity_q, parity_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             ext_q, ext_d;
    logic             brk_q, brk_d;
    logic [8:0]       held_q, held_d;
    logic             cmd_valid_q, cmd_valid_d;
    game_cmd_t        cmd_data_q, cmd_data_d;
    logic             frame_err_q, frame_err_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;

    cmd_map_t map_res;
    logic     timed_out;

    assign map_res   = map_scancode(ext_q, shift_q);
    assign timed_out = (timer_q == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        // NOTE: every _d gets a default before the case so no path can infer a latch.
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        timer_d     = timer_q;
        ext_d       = ext_q;
        brk_d       = brk_q;
        held_d      = held_q;
        cmd_valid_d = 1'b0;
        cmd_data_d  = cmd_data_q;
        frame_err_d = 1'b0;
        err_count_d = err_count_q;

        case (state_q)
            IDLE: begin
                if (fall) begin
                    if (!data) begin
                        bit_cnt_d = '0;
                        timer_d   = '0;
                        state_d   = RECV;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            RECV: begin
                if (fall) begin
                    timer_d = '0;
                    if (bit_cnt_q == 4'd8) begin
                        parity_d = data;
                        state_d  = STOP;
                    end else begin
                        shift_d   = {data, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end else if (timed_out) begin
                    frame_err_d = 1'b1;
                    shift_d     = '0;
                    state_d     = IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            STOP: begin
                if (fall) begin
                    // Odd parity: data byte plus parity bit must hold an odd number of ones.
                    if (data && (^{shift_q, parity_q})) begin
                        state_d = DECODE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = IDLE;
                    end
                end else if (timed_out) begin
                    frame_err_d = 1'b1;
                    shift_d     = '0;
                    state_d     = IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            DECODE: begin
                state_d = IDLE;
                if (shift_q == SC_EXT) begin
                    ext_d = 1'b1;
                end else if (shift_q == SC_BRK) begin
                    brk_d = 1'b1;
                end else begin
                    ext_d = 1'b0;
                    brk_d = 1'b0;
                    // held_q only ever stores mapped keys, so 9'h000 doubles as "no key held".
                    if (map_res.valid) begin
                        if (brk_q) begin
                            if (held_q == {ext_q, shift_q}) held_d = '0;
                        end else if (REPEAT_EN || (held_q != {ext_q, shift_q})) begin
                            cmd_valid_d = 1'b1;
                            cmd_data_d  = map_res.cmd;
                            held_d      = {ext_q, shift_q};
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (frame_err_d && (err_count_q != '1)) err_count_d = err_count_q + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            timer_q     <= '0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            held_q      <= '0;
            cmd_valid_q <= 1'b0;
            cmd_data_q  <= CMD_NONE;
            frame_err_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            timer_q     <= timer_d;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            held_q      <= held_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_data_q  <= cmd_data_d;
            frame_err_q <= frame_err_d;
            err_count_q <= err_count_d;
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_data  = cmd_data_q;
    assign frame_err = frame_err_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_ps2_key_receiver.sv
// Bench for ps2_key_receiver: two instances (repeats suppressed / forwarded)
// share one PS/2 line and are compared against a scan-code level model.
module tb_ps2_key_receiver;

    localparam int HALF = 10;
    localparam int TO   = 400;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clock = 1'b1;
    logic       ps2_data = 1'b1;
    logic       cv0, cv1, fe0, fe1;
    logic [2:0] cd0, cd1;
    logic [7:0] ec0, ec1;

    ps2_key_receiver #(.TIMEOUT_CYCLES(TO), .REPEAT_EN(1'b0), .ERR_W(8)) dut0 (
        .clock(clock), .reset(reset), .ps2_clock(ps2_clock), .ps2_data(ps2_data),
        .cmd_valid(cv0), .cmd_data(cd0), .frame_err(fe0), .err_count(ec0)
    );

    ps2_key_receiver #(.TIMEOUT_CYCLES(TO), .REPEAT_EN(1'b1), .ERR_W(8)) dut1 (
        .clock(clock), .reset(reset), .ps2_clock(ps2_clock), .ps2_data(ps2_data),
        .cmd_valid(cv1), .cmd_data(cd1), .frame_err(fe1), .err_count(ec1)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int n_cv0 = 0, n_cv1 = 0, n_fe0 = 0, n_fe1 = 0;
    int last_lat;

    always @(negedge clock) begin
        if (cv0) n_cv0++;
        if (cv1) n_cv1++;
        if (fe0) n_fe0++;
        if (fe1) n_fe1++;
    end

    // Reference model state: prefix flags, held key (-1 = none), error count.
    bit m_ext, m_brk;
    int m_held, m_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int cmd_of(input bit ext, input logic [7:0] code);
        if (!ext) begin
            case (code)
                8'h1D: return 1;
                8'h1B: return 2;
                8'h1C: return 3;
                8'h23: return 4;
                8'h3B: return 5;
                8'h42: return 6;
                8'h29: return 7;
                default: return 0;
            endcase
        end
        case (code)
            8'h75: return 1;
            8'h72: return 2;
            8'h6B: return 3;
            8'h74: return 4;
            default: return 0;
        endcase
    endfunction

    task automatic model_byte(input logic [7:0] b, output int e0, output int e1);
        int key, c;
        e0 = 0;
        e1 = 0;
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else begin
            key = m_ext ? 256 + int'(b) : int'(b);
            c   = cmd_of(m_ext, b);
            if (c != 0) begin
                if (m_brk) begin
                    if (m_held == key) m_held = -1;
                end else begin
                    e1 = c;
                    if (m_held != key) begin
                        e0     = c;
                        m_held = key;
                    end
                end
            end
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic clock_bit(input logic b);
        ps2_data = b;
        repeat (HALF) @(negedge clock);
        ps2_clock = 1'b0;
        repeat (HALF) @(negedge clock);
        ps2_clock = 1'b1;
    endtask

    // kind: 0 good frame, 1 parity flipped, 2 stop bit low
    task automatic send_frame(input logic [7:0] b, input int kind);
        logic [10:0] f;
        f = {(kind == 2) ? 1'b0 : 1'b1, (~^b) ^ (kind == 1), b, 1'b0};
        for (int i = 0; i < 10; i++) clock_bit(f[i]);
        ps2_data = f[10];
        repeat (HALF) @(negedge clock);
        ps2_clock = 1'b0;
        last_lat = -1;
        for (int j = 1; j <= HALF; j++) begin
            @(negedge clock);
            if (cv0 && last_lat < 0) last_lat = j;
        end
        ps2_clock = 1'b1;
        ps2_data  = 1'b1;
        repeat (2 * HALF) @(negedge clock);
    endtask

    task automatic byte_step(input string tag, input logic [7:0] b, input int kind);
        int e0, e1, s_cv0, s_cv1, s_fe0, s_fe1;
        s_cv0 = n_cv0;
        s_cv1 = n_cv1;
        s_fe0 = n_fe0;
        s_fe1 = n_fe1;
        e0 = 0;
        e1 = 0;
        if (kind == 0) model_byte(b, e0, e1);
        else if (m_err < 255) m_err++;
        send_frame(b, kind);
        check({tag, "/cv0"}, n_cv0 - s_cv0, (e0 != 0));
        if (e0 != 0) check({tag, "/cd0"}, cd0, e0);
        check({tag, "/cv1"}, n_cv1 - s_cv1, (e1 != 0));
        if (e1 != 0) check({tag, "/cd1"}, cd1, e1);
        check({tag, "/fe0"}, n_fe0 - s_fe0, (kind != 0));
        check({tag, "/fe1"}, n_fe1 - s_fe1, (kind != 0));
        check({tag, "/ec0"}, ec0, m_err);
        check({tag, "/ec1"}, ec1, m_err);
    endtask

    initial begin
        logic [7:0] pool [11];
        logic [7:0] b;
        int s0, s1, r, kind;

        pool = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h3B, 8'h42, 8'h29, 8'h75, 8'h72, 8'h6B, 8'h74};
        m_ext = 1'b0; m_brk = 1'b0; m_held = -1; m_err = 0;

        reset = 1'b1;
        repeat (4) @(negedge clock);
        check("rst/cv0", cv0, 0);
        check("rst/cd0", cd0, 0);
        check("rst/fe0", fe0, 0);
        check("rst/ec0", ec0, 0);
        check("rst/cv1", cv1, 0);
        check("rst/ec1", ec1, 0);
        reset = 1'b0;
        repeat (3) @(negedge clock);

        byte_step("w", 8'h1D, 0);
        check("w/latency", last_lat, 5);

        byte_step("ext_make_pre", 8'hE0, 0);
        byte_step("ext_make", 8'h6B, 0);
        byte_step("ext_brk_pre", 8'hE0, 0);
        byte_step("ext_brk_f0", 8'hF0, 0);
        byte_step("ext_brk", 8'h6B, 0);
        byte_step("ext_remake_pre", 8'hE0, 0);
        byte_step("ext_remake", 8'h6B, 0);

        s0 = n_cv0;
        s1 = n_cv1;
        byte_step("d1", 8'h23, 0);
        byte_step("d2", 8'h23, 0);
        byte_step("d3", 8'h23, 0);
        byte_step("d_f0", 8'hF0, 0);
        byte_step("d_brk", 8'h23, 0);
        byte_step("d4", 8'h23, 0);
        check("repeat0_strobes", n_cv0 - s0, 2);
        check("repeat1_strobes", n_cv1 - s1, 4);

        byte_step("space_badpar", 8'h29, 1);
        check("space_badpar/ec_is_1", ec0, 1);
        byte_step("space", 8'h29, 0);

        // Clock line stalls after the start bit and 4 data bits.
        s0 = n_fe0;
        s1 = n_fe1;
        b  = 8'h1B;
        clock_bit(1'b0);
        for (int i = 0; i < 4; i++) clock_bit(b[i]);
        ps2_data = 1'b1;
        repeat (TO + 50) @(negedge clock);
        m_err++;
        check("timeout/fe0", n_fe0 - s0, 1);
        check("timeout/fe1", n_fe1 - s1, 1);
        check("timeout/ec0", ec0, m_err);
        byte_step("s_after_to", 8'h1B, 0);

        // Reset in the middle of a frame, held while the rest of it is clocked out.
        b = 8'h5A;
        clock_bit(1'b0);
        for (int i = 0; i < 5; i++) clock_bit(b[i]);
        reset = 1'b1;
        @(negedge clock);
        check("midrst/cv0", cv0, 0);
        check("midrst/cd0", cd0, 0);
        check("midrst/fe0", fe0, 0);
        check("midrst/ec0", ec0, 0);
        check("midrst/cd1", cd1, 0);
        check("midrst/ec1", ec1, 0);
        for (int i = 5; i < 8; i++) clock_bit(b[i]);
        clock_bit(~^b);
        clock_bit(1'b1);
        m_ext = 1'b0; m_brk = 1'b0; m_held = -1; m_err = 0;
        s0 = n_fe0;
        reset = 1'b0;
        repeat (3 * HALF) @(negedge clock);
        check("midrst/no_err", n_fe0 - s0, 0);
        byte_step("k_after_rst", 8'h42, 0);

        for (int n = 0; n < 60; n++) begin
            r    = $urandom_range(0, 9);
            kind = 0;
            case (r)
                0:       b = 8'hE0;
                1:       b = 8'hF0;
                7:       b = 8'($urandom);
                8, 9:    begin
                             b = pool[$urandom_range(0, 10)];
                             if (r == 9) kind = $urandom_range(1, 2);
                         end
                default: b = pool[$urandom_range(0, 10)];
            endcase
            byte_step($sformatf("rnd%0d", n), b, kind);
        end

        s0 = n_fe0;
        s1 = n_fe1;
        repeat (300) clock_bit(1'b1);
        repeat (HALF) @(negedge clock);
        check("sat/fe0_pulses", n_fe0 - s0, 300);
        check("sat/fe1_pulses", n_fe1 - s1, 300);
        check("sat/ec0", ec0, 255);
        check("sat/ec1", ec1, 255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
